// File: rtl/mult_div_unit_if.sv
// Controller-side bus of the multicycle multiply/divide unit.
// The master drives the request; the slave returns HI/LO and status.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, mode, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, mode, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and restoring divide into HI/LO.
// Works on operand magnitudes for WIDTH cycles, then sign-corrects in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             neg_hi, neg_lo, div_zero_r;
  logic [CW-1:0]    cnt;
  logic             busy, done;

  logic               accept, is_div, is_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, sh_rem;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign accept    = bus.start && (state == S_IDLE || state == S_DONE);
  assign is_div    = mode_r[1];
  assign is_signed = ~mode_r[0];
  assign a_neg     = is_signed & a_r[WIDTH-1];
  assign b_neg     = is_signed & b_r[WIDTH-1];
  assign b_zero    = (b_r == '0);
  assign mag_a     = a_neg ? -a_r : a_r;
  assign mag_b     = b_neg ? -b_r : b_r;

  // Multiply: acc_lo holds the unconsumed multiplier bits, product shifts in from the top.
  assign add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  // The remainder always stays below the divisor, so a WIDTH-bit subtract suffices.
  assign sh_rem    = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge    = (sh_rem >= {1'b0, opnd_b});
  assign rem_sub   = sh_rem[WIDTH-1:0] - opnd_b;

  assign prod      = {acc_hi, acc_lo};
  assign prod_fix  = neg_lo ? -prod : prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nx = S_PREP;
      S_PREP: begin
        busy     = 1'b1;
        state_nx = (is_div && b_zero) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
      end
      S_FIX: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = bus.start ? S_PREP : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r     <= '0;
      a_r        <= '0;
      b_r        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd_b     <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      neg_hi     <= 1'b0;
      neg_lo     <= 1'b0;
      div_zero_r <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        a_r        <= bus.a;
        b_r        <= bus.b;
        mode_r     <= bus.mode;
        div_zero_r <= 1'b0;
      end
      case (state)
        S_PREP: begin
          acc_hi <= '0;
          acc_lo <= mag_a;
          opnd_b <= mag_b;
          cnt    <= '0;
          neg_lo <= a_neg ^ b_neg;
          // Remainder follows the dividend; a product's sign covers both halves.
          neg_hi <= is_div ? a_neg : (a_neg ^ b_neg);
          if (is_div && b_zero) div_zero_r <= 1'b1;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= rem_ge ? rem_sub : sh_rem[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
          end else begin
            acc_hi <= add_sum[WIDTH:1];
            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (is_div) begin
            lo_r <= neg_lo ? -acc_lo : acc_lo;
            hi_r <= neg_hi ? -acc_hi : acc_hi;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes model results,
// a monitor pops and compares on every done pulse, including latency.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  int           acc_q[$];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder takes the dividend's sign.
  task automatic model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e);
    logic [63:0] p, qv, rv;
    longint      sa, sbv;
    e.dz  = 1'b0;
    e.lat = W + 3;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (m)
      2'b00: begin
        p = sa * sbv;
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      2'b10: begin
        if (b == '0) begin
          e.dz = 1'b1; e.lat = 2;
        end else begin
          qv = sa / sbv;
          rv = sa % sbv;
          model_lo = qv[31:0];
          model_hi = rv[31:0];
        end
      end
      default: begin
        if (b == '0) begin
          e.dz = 1'b1; e.lat = 2;
        end else begin
          model_lo = a / b;
          model_hi = a % b;
        end
      end
    endcase
    e.hi = model_hi;
    e.lo = model_lo;
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset && bus.start && !bus.busy) acc_q.push_back(cyc);
  end

  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (reset && bus.done) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: actual done=1 required no pending op");
      end else begin
        e   = sbq.pop_front();
        lat = (acc_q.size() != 0) ? (cyc - acc_q.pop_front() + 1) : -1;
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("div_zero", bus.div_zero, e.dz);
        check("latency", lat, e.lat);
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin n++; @(negedge clk); end
    if (bus.busy) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: actual busy=1 required busy=0");
    end
    model(m, a, b, e);
    sbq.push_back(e);
    bus.start = 1'b1; bus.mode = m; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.mode = 2'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: actual %0d pending required 0", sbq.size());
      sbq.delete(); acc_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic          seen;
    logic [1:0]    m;
    logic [W-1:0]  ra, rb;

    bus.start = 1'b0; bus.mode = '0; bus.a = '0; bus.b = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_div_zero", bus.div_zero, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    n = 0;
    while (bus.busy && n < 100) begin n++; @(negedge clk); end
    check("t1_busy_cycles", n, 34);
    wait_drain();
    check("t1_hi", bus.hi, 32'hFFFF_FFFF);
    check("t1_lo", bus.lo, 32'hFFFF_FFEB);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_drain();
    check("t2_hi", bus.hi, 32'hFFFF_FFFE);
    check("t2_lo", bus.lo, 32'h0000_0001);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_drain();
    check("t3s_lo", bus.lo, 32'hFFFF_FFFD);
    check("t3s_hi", bus.hi, 32'hFFFF_FFFF);
    issue(2'b11, 32'd7, 32'd2);
    wait_drain();
    check("t3u_lo", bus.lo, 32'd3);
    check("t3u_hi", bus.hi, 32'd1);

    issue(2'b11, 32'h5678_1234, 32'h0001_0000);
    issue(2'b10, 32'd5, 32'd0);
    wait_drain();
    check("t4_div_zero", bus.div_zero, 1'b1);
    check("t4_hi", bus.hi, 32'h1234);
    check("t4_lo", bus.lo, 32'h5678);
    issue(2'b11, 32'd100, 32'd7);
    check("t4_dz_cleared", bus.div_zero, 1'b0);
    wait_drain();

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain();
    check("t5_min_lo", bus.lo, 32'h8000_0000);
    check("t5_min_hi", bus.hi, 32'h0);
    check("t5_min_dz", bus.div_zero, 1'b0);
    issue(2'b10, 32'd0, 32'd9);
    wait_drain();
    check("t5_zero_lo", bus.lo, 32'h0);
    check("t5_zero_hi", bus.hi, 32'h0);

    issue(2'b00, 32'd12345, 32'hFFFF_FF00);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b11; bus.a = 32'd99; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(2'b11, 32'hCAFE_F00D, 32'd3);
    wait_drain();

    issue(2'b01, $urandom, $urandom);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_hi", bus.hi, '0);
    check("abort_lo", bus.lo, '0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    sbq.delete(); acc_q.delete();
    model_hi = '0; model_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);

    for (int i = 0; i < 60; i++) begin
      m  = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 5));
        3: ra = '0;
        default: ;
      endcase
      issue(m, ra, rb);
      repeat ($urandom_range(0, 2) * 20) @(negedge clk);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
